ccd_line_scheduler: RTL and testbench

Line-scan sequencer for the linear CCD drivers (TCD1290D_driver, S12379_driver). It gates the driver clock phases and generates the SH transfer pulse, with programmable integration period, SH width and guard times. It counts the driver's per-pixel strobe to frame each line with valid, index and last flags. It sits between the host configuration registers and the sensor driver/ADC capture path, all in the sys_clk domain.

---
 rtl/ccd_line_scheduler_if.sv | 48 ++++
 rtl/ccd_line_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_ccd_line_scheduler.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccd_line_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : ccd_line_scheduler_if
// Description : Host/driver-side bundle for the CCD line scheduler. It carries
//               the scan controls, timing configuration, the driver pixel
//               strobe and all framing/status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface ccd_line_scheduler_if #(
  parameter int PIX_W    = 12,
  parameter int PERIOD_W = 24,
  parameter int SH_W     = 8
);
  // Control and configuration, driven by host registers / sensor driver
  logic                run;
  logic                single;
  logic [PERIOD_W-1:0] period;
  logic [SH_W-1:0]     sh_width;
  logic [SH_W-1:0]     sh_guard;
  logic                pix_stb;
  logic                clr_err;

  // Sequencing, framing and status, driven by the scheduler
  logic                drv_en;
  logic                sh;
  logic                line_start;
  logic                pix_valid;
  logic [PIX_W-1:0]    pix_idx;
  logic                line_last;
  logic [15:0]         line_cnt;
  logic                busy;
  logic                overrun;

  // Host / environment side
  modport master (
    output run, single, period, sh_width, sh_guard, pix_stb, clr_err,
    input  drv_en, sh, line_start, pix_valid, pix_idx, line_last,
           line_cnt, busy, overrun
  );

  // Scheduler side
  modport slave (
    input  run, single, period, sh_width, sh_guard, pix_stb, clr_err,
    output drv_en, sh, line_start, pix_valid, pix_idx, line_last,
           line_cnt, busy, overrun
  );
endinterface
`default_nettype wire

// File: rtl/ccd_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : ccd_line_scheduler
// Description : Line-scan sequencer for linear CCD drivers. Gates the driver
//               clock phases, generates the SH transfer pulse with guard
//               times, frames the driver pixel strobes into an indexed line
//               and enforces a programmable line period with overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ccd_line_scheduler #(
  parameter int PIX_NUM  = 3048,
  parameter int PIX_W    = 12,
  parameter int PERIOD_W = 24,
  parameter int SH_W     = 8
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  ccd_line_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GUARD_A = 3'd1,
    S_SH_HI   = 3'd2,
    S_GUARD_B = 3'd3,
    S_READOUT = 3'd4,
    S_WAIT    = 3'd5
  } state_t;

  // Index of the final pixel of a line in pix_idx width
  localparam logic [PIX_W-1:0] c_last_idx = PIX_W'(PIX_NUM - 1);

  // ---------------------------------------------------------------------------
  // State, shadow configuration and counters
  // ---------------------------------------------------------------------------
  state_t              r_state;
  logic [PERIOD_W-1:0] r_per_lim;   // latched period-1 (period 0 behaves as 1)
  logic [SH_W-1:0]     r_shw_q;     // latched sh_width
  logic [SH_W-1:0]     r_shg_q;     // latched sh_guard
  logic [PERIOD_W-1:0] r_pcnt;      // cycles since line_start, saturating
  logic [SH_W-1:0]     r_dcnt;      // cycles spent in the current guard/SH phase
  logic [PIX_W-1:0]    r_pix_cnt;   // strobes accepted so far this line
  logic                r_expired;   // period limit already reached this line

  // Registered outputs
  logic                r_drv_en;
  logic                r_sh;
  logic                r_line_start;
  logic                r_pix_valid;
  logic [PIX_W-1:0]    r_pix_idx;
  logic                r_line_last;
  logic [15:0]         r_line_cnt;
  logic                r_busy;
  logic                r_overrun;

  // ---------------------------------------------------------------------------
  // Decode helpers
  // ---------------------------------------------------------------------------
  state_t              w_nxt;
  logic                w_enter;       // a new line begins at the next edge
  state_t              w_entry_state; // first state of a new line
  logic                w_pcnt_at_lim;
  logic [SH_W-1:0]     w_sh_m1;
  logic [SH_W-1:0]     w_g_m1;
  logic                w_pre_wait;
  logic                w_ovr_set;
  logic                w_pix_take;
  logic                w_pix_last;
  logic                w_phase_chg;

  assign w_pcnt_at_lim = (r_pcnt == r_per_lim);
  // A zero SH width still produces a one-cycle pulse
  assign w_sh_m1       = (r_shw_q == '0) ? '0 : (r_shw_q - 1'b1);
  assign w_g_m1        = r_shg_q - 1'b1;
  // With no guard time the line opens directly with the SH pulse
  assign w_entry_state = (bus.sh_guard == '0) ? S_SH_HI : S_GUARD_A;

  assign w_pre_wait = (r_state == S_GUARD_A) || (r_state == S_SH_HI) ||
                      (r_state == S_GUARD_B) || (r_state == S_READOUT);
  // Only the first time the limit is hit in a line counts as an overrun event
  assign w_ovr_set  = w_pre_wait && w_pcnt_at_lim && !r_expired;

  // r_line_last marks the cycle after the final strobe; strobes are ignored then
  assign w_pix_take = (r_state == S_READOUT) && bus.pix_stb && !r_line_last;
  assign w_pix_last = w_pix_take && (r_pix_cnt == c_last_idx);

  assign w_phase_chg = (w_nxt != r_state) || w_enter;

  // Next-state decode for the line sequencer
  always_comb begin
    w_nxt   = r_state;
    w_enter = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.run || bus.single) begin
          w_enter = 1'b1;
        end
      end
      S_GUARD_A: begin
        if (r_dcnt == w_g_m1) begin
          w_nxt = S_SH_HI;
        end
      end
      S_SH_HI: begin
        if (r_dcnt == w_sh_m1) begin
          w_nxt = (r_shg_q == '0) ? S_READOUT : S_GUARD_B;
        end
      end
      S_GUARD_B: begin
        if (r_dcnt == w_g_m1) begin
          w_nxt = S_READOUT;
        end
      end
      S_READOUT: begin
        // Leave once the last pixel has been presented
        if (r_line_last) begin
          if (!bus.run) begin
            w_nxt = S_IDLE;
          end else if (w_pcnt_at_lim) begin
            // Period already spent: start the next line back-to-back
            w_enter = 1'b1;
          end else begin
            w_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!bus.run) begin
          w_nxt = S_IDLE;
        end else if (w_pcnt_at_lim) begin
          w_enter = 1'b1;
        end
      end
      default: begin
        w_nxt = S_IDLE;
      end
    endcase
    if (w_enter) begin
      w_nxt = w_entry_state;
    end
  end

  // Sequencer state, counters, shadow registers and registered outputs
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_per_lim    <= '0;
      r_shw_q      <= '0;
      r_shg_q      <= '0;
      r_pcnt       <= '0;
      r_dcnt       <= '0;
      r_pix_cnt    <= '0;
      r_expired    <= 1'b0;
      r_drv_en     <= 1'b0;
      r_sh         <= 1'b0;
      r_line_start <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_idx    <= '0;
      r_line_last  <= 1'b0;
      r_line_cnt   <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_busy       <= (w_nxt != S_IDLE);
      r_drv_en     <= (w_nxt != S_IDLE);
      r_sh         <= (w_nxt == S_SH_HI);
      r_line_start <= w_enter;

      // Line entry: capture configuration so it is stable for the whole line
      if (w_enter) begin
        r_per_lim <= (bus.period == '0) ? '0 : (bus.period - 1'b1);
        r_shw_q   <= bus.sh_width;
        r_shg_q   <= bus.sh_guard;
      end

      // Period counter, measured from line_start and saturating at the limit
      if (w_enter) begin
        r_pcnt <= '0;
      end else if ((r_state != S_IDLE) && !w_pcnt_at_lim) begin
        r_pcnt <= r_pcnt + 1'b1;
      end

      if (w_enter) begin
        r_expired <= 1'b0;
      end else if ((r_state != S_IDLE) && w_pcnt_at_lim) begin
        r_expired <= 1'b1;
      end

      // Phase duration counter for GUARD_A / SH_HI / GUARD_B
      if (w_phase_chg) begin
        r_dcnt <= '0;
      end else if (w_pre_wait && (r_state != S_READOUT)) begin
        r_dcnt <= r_dcnt + 1'b1;
      end

      // Pixel framing: one qualified pixel per accepted strobe
      r_pix_valid <= 1'b0;
      r_line_last <= 1'b0;
      if (w_enter) begin
        r_pix_cnt <= '0;
      end else if (w_pix_take) begin
        r_pix_valid <= 1'b1;
        r_pix_idx   <= r_pix_cnt;
        r_line_last <= w_pix_last;
        r_pix_cnt   <= r_pix_cnt + 1'b1;
      end
      if (w_pix_last) begin
        r_line_cnt <= r_line_cnt + 1'b1;
      end

      // Sticky overrun; a new overrun event wins over a simultaneous clear
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (bus.clr_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.drv_en     = r_drv_en;
  assign bus.sh         = r_sh;
  assign bus.line_start = r_line_start;
  assign bus.pix_valid  = r_pix_valid;
  assign bus.pix_idx    = r_pix_idx;
  assign bus.line_last  = r_line_last;
  assign bus.line_cnt   = r_line_cnt;
  assign bus.busy       = r_busy;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_ccd_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccd_line_scheduler
// Description : Scoreboard bench for ccd_line_scheduler. A time-based line
//               model predicts line_start, SH pulses, pixels, busy and
//               overrun transitions; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccd_line_scheduler;

  localparam int PIX_NUM  = 16;
  localparam int PIX_W    = 12;
  localparam int PERIOD_W = 24;
  localparam int SH_W     = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ccd_line_scheduler_if #(.PIX_W(PIX_W), .PERIOD_W(PERIOD_W), .SH_W(SH_W)) ifc ();

  ccd_line_scheduler #(
    .PIX_NUM  (PIX_NUM),
    .PIX_W    (PIX_W),
    .PERIOD_W (PERIOD_W),
    .SH_W     (SH_W)
  ) dut (
    .sys_clk (clk),
    .reset   (reset),
    .bus     (ifc)
  );

  typedef struct { int cyc; int idx; bit last; int lc; } pix_t;
  typedef struct { int rise; int width; } sh_t;
  typedef struct { int cyc; bit val; } ev_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;

  int   q_ls[$];
  sh_t  q_sh[$];
  pix_t q_pix[$];
  ev_t  q_busy[$];
  ev_t  q_ovr[$];

  // Reference model: a line is described by its start time and parameters
  int m_phase = 0;   // 0 idle, 1 inside a line (start..last pixel), 2 waiting
  int m_T, m_per, m_g, m_w, m_R, m_cnt, m_nextT;
  int m_end = -1;
  int m_lines = 0;
  bit m_busy = 1'b0;
  bit m_ovr  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic start_line(input int t);
    m_T     = t;
    m_g     = int'(ifc.sh_guard);
    m_w     = (ifc.sh_width == '0) ? 1 : int'(ifc.sh_width);
    m_per   = (ifc.period == '0) ? 1 : int'(ifc.period);
    m_R     = t + 2 * m_g + m_w;
    m_cnt   = 0;
    m_end   = -1;
    q_ls.push_back(t);
    q_sh.push_back('{t + m_g, m_w});
  endtask

  // Evaluate the model for cycle n with the inputs currently driven
  task automatic model_eval(input int n);
    int nphase;
    bit ovr_set;
    bit nb;
    bit novr;
    nphase  = m_phase;
    ovr_set = 1'b0;
    case (m_phase)
      0: begin
        if (ifc.run || ifc.single) begin
          start_line(n + 1);
          nphase = 1;
        end
      end
      1: begin
        if (n == m_T + m_per - 1) ovr_set = 1'b1;
        if (n == m_end) begin
          if (ifc.run) begin
            if (n - m_T >= m_per - 1) start_line(n + 1);
            else begin
              nphase  = 2;
              m_nextT = m_T + m_per;
            end
          end else begin
            nphase = 0;
          end
        end else if (ifc.pix_stb && n >= m_R && m_cnt < PIX_NUM) begin
          m_cnt++;
          if (m_cnt == PIX_NUM) begin
            m_lines++;
            m_end = n + 1;
          end
          q_pix.push_back('{n + 1, m_cnt - 1, (m_cnt == PIX_NUM), m_lines % 65536});
        end
      end
      default: begin
        if (!ifc.run) nphase = 0;
        else if (n == m_nextT - 1) begin
          start_line(n + 1);
          nphase = 1;
        end
      end
    endcase
    nb = (nphase != 0);
    if (nb != m_busy) q_busy.push_back('{n + 1, nb});
    m_busy = nb;
    novr = ovr_set ? 1'b1 : (ifc.clr_err ? 1'b0 : m_ovr);
    if (novr != m_ovr) q_ovr.push_back('{n + 1, novr});
    m_ovr   = novr;
    m_phase = nphase;
  endtask

  task automatic step();
    model_eval(cyc);
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int per, input int w, input int g);
    ifc.period   = PERIOD_W'(per);
    ifc.sh_width = SH_W'(w);
    ifc.sh_guard = SH_W'(g);
  endtask

  task automatic rand_cfg();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0)      ifc.period = PERIOD_W'($urandom_range(0, 2));
    else if (sel == 1) ifc.period = PERIOD_W'($urandom_range(20, 90));
    else               ifc.period = PERIOD_W'($urandom_range(120, 260));
    ifc.sh_width = SH_W'($urandom_range(0, 5));
    ifc.sh_guard = SH_W'($urandom_range(0, 3));
  endtask

  task automatic flush();
    int k;
    k = 0;
    ifc.run     = 1'b0;
    ifc.single  = 1'b0;
    ifc.clr_err = 1'b0;
    while (m_phase != 0 && k < 3000) begin
      ifc.pix_stb = ($urandom_range(0, 2) == 0);
      step();
      k++;
    end
    if (m_phase != 0) fail("flush_timeout", k, 3000);
    ifc.pix_stb = 1'b0;
    repeat (3) step();
  endtask

  // Monitor: compares every DUT event against the scoreboard queues
  int   mon_rise = 0;
  bit   p_sh = 1'b0, p_busy = 1'b0, p_ovr = 1'b0;
  int   e_ls;
  sh_t  e_sh;
  pix_t e_px;
  ev_t  e_ev;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ifc.line_start) begin
        if (q_ls.size() == 0) fail("line_start_unexpected", cyc, -1);
        else begin
          e_ls = q_ls.pop_front();
          check("line_start_cycle", cyc, e_ls);
        end
      end
      if (ifc.sh && !p_sh) mon_rise = cyc;
      if (!ifc.sh && p_sh) begin
        if (q_sh.size() == 0) fail("sh_unexpected", mon_rise, -1);
        else begin
          e_sh = q_sh.pop_front();
          check("sh_rise_cycle", mon_rise, e_sh.rise);
          check("sh_width", cyc - mon_rise, e_sh.width);
        end
      end
      p_sh = ifc.sh;
      if (ifc.pix_valid) begin
        if (q_pix.size() == 0) fail("pix_unexpected", int'(ifc.pix_idx), -1);
        else begin
          e_px = q_pix.pop_front();
          check("pix_cycle", cyc, e_px.cyc);
          check("pix_idx", int'(ifc.pix_idx), e_px.idx);
          check("line_last", int'(ifc.line_last), int'(e_px.last));
          if (e_px.last) check("line_cnt", int'(ifc.line_cnt), e_px.lc);
        end
      end else if (ifc.line_last) begin
        fail("line_last_without_valid", 1, 0);
      end
      if (ifc.busy != p_busy) begin
        if (q_busy.size() == 0) fail("busy_unexpected", int'(ifc.busy), int'(p_busy));
        else begin
          e_ev = q_busy.pop_front();
          check("busy_cycle", cyc, e_ev.cyc);
          check("busy_value", int'(ifc.busy), int'(e_ev.val));
        end
      end
      p_busy = ifc.busy;
      if (ifc.overrun != p_ovr) begin
        if (q_ovr.size() == 0) fail("overrun_unexpected", int'(ifc.overrun), int'(p_ovr));
        else begin
          e_ev = q_ovr.pop_front();
          check("overrun_cycle", cyc, e_ev.cyc);
          check("overrun_value", int'(ifc.overrun), int'(e_ev.val));
        end
      end
      p_ovr = ifc.overrun;
      if (ifc.drv_en != ifc.busy) fail("drv_en_vs_busy", int'(ifc.drv_en), int'(ifc.busy));
    end
  end

  initial begin
    int k;
    ifc.run = 1'b0; ifc.single = 1'b0; ifc.pix_stb = 1'b0; ifc.clr_err = 1'b0;
    set_cfg(200, 4, 2);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_busy",      int'(ifc.busy),       0);
    check("rst_drv_en",    int'(ifc.drv_en),     0);
    check("rst_sh",        int'(ifc.sh),         0);
    check("rst_overrun",   int'(ifc.overrun),    0);
    check("rst_line_cnt",  int'(ifc.line_cnt),   0);
    check("rst_pix_valid", int'(ifc.pix_valid),  0);
    check("rst_line_strt", int'(ifc.line_start), 0);
    mon_en = 1'b1;

    // Single line, guard 2, width 4, strobe every 4 cycles
    ifc.single = 1'b1; step(); ifc.single = 1'b0;
    for (int i = 0; i < 120; i++) begin ifc.pix_stb = (i % 4 == 3); step(); end
    flush();
    check("t1_line_cnt", int'(ifc.line_cnt), m_lines % 65536);

    // Continuous lines with a comfortable period
    ifc.run = 1'b1;
    for (int i = 0; i < 650; i++) begin ifc.pix_stb = (i % 4 == 1); step(); end
    flush();

    // Period shorter than readout: back-to-back lines, overrun, clearing
    set_cfg(50, 4, 2);
    ifc.run = 1'b1;
    for (int i = 0; i < 320; i++) begin
      ifc.pix_stb = (i % 4 == 2);
      ifc.clr_err = (i == 100) || (i == 230);
      step();
    end
    ifc.clr_err = 1'b0;
    flush();
    ifc.clr_err = 1'b1; step(); ifc.clr_err = 1'b0;

    // Drop run at pixel 5: line completes then idles
    set_cfg(120, 4, 2);
    ifc.run = 1'b1;
    k = 0;
    while (!(m_phase == 1 && m_cnt == 5) && k < 500) begin
      ifc.pix_stb = (k % 4 == 0); step(); k++;
    end
    if (k >= 500) fail("run_drop_timeout", k, 500);
    flush();
    repeat (20) step();
    check("t4_busy",   int'(ifc.busy),   0);
    check("t4_drv_en", int'(ifc.drv_en), 0);

    // Zero guard and zero width: one-cycle SH coincident with line_start
    set_cfg(100, 0, 0);
    ifc.single = 1'b1; step(); ifc.single = 1'b0;
    for (int i = 0; i < 60; i++) begin ifc.pix_stb = (i % 2 == 0); step(); end
    flush();

    // Randomized operation
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) ifc.run = ~ifc.run;
      ifc.single  = ($urandom_range(0, 49) == 0);
      ifc.clr_err = ($urandom_range(0, 59) == 0);
      ifc.pix_stb = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) rand_cfg();
      step();
    end
    flush();

    check("q_ls_left",   q_ls.size(),   0);
    check("q_sh_left",   q_sh.size(),   0);
    check("q_pix_left",  q_pix.size(),  0);
    check("q_busy_left", q_busy.size(), 0);
    check("q_ovr_left",  q_ovr.size(),  0);
    check("final_line_cnt", int'(ifc.line_cnt), m_lines % 65536);

    // Reset in the middle of the SH pulse
    mon_en = 1'b0;
    ifc.run = 1'b0;
    set_cfg(300, 4, 2);
    ifc.single = 1'b1;
    @(posedge clk); #1;
    ifc.single = 1'b0;
    k = 0;
    while (!ifc.sh && k < 20) begin @(posedge clk); #1; k++; end
    if (!ifc.sh) fail("rst_reach_sh", 0, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_sh",        int'(ifc.sh),         0);
    check("mid_rst_drv_en",    int'(ifc.drv_en),     0);
    check("mid_rst_busy",      int'(ifc.busy),       0);
    check("mid_rst_line_cnt",  int'(ifc.line_cnt),   0);
    check("mid_rst_line_strt", int'(ifc.line_start), 0);
    check("mid_rst_overrun",   int'(ifc.overrun),    0);
    for (int i = 0; i < 30; i++) begin
      ifc.pix_stb = (i % 2 == 0);
      @(posedge clk); #1;
      check("post_rst_pix_valid", int'(ifc.pix_valid), 0);
      check("post_rst_sh",        int'(ifc.sh),        0);
    end
    ifc.pix_stb = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
